// File: rtl/alu_op_sequencer_if.sv
// Decode-to-EX handshake bundle for alu_op_sequencer: instruction fields in,
// registered ALU op out, and MDU control pulses.
interface alu_op_sequencer_if #(
  parameter int ALUOP_W = 5
);
  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1. A producer holds valid and its payload stable until that edge,
  // and ready may depend combinationally on the consumer's own state and on
  // out_ready, but never on in_valid.
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic               out_valid;
  logic               out_ready;
  logic [ALUOP_W-1:0] alu_op;
  logic               is_mdu;
  logic               illegal;
  logic               mdu_start;
  logic               mdu_kill;

  modport master (
    output flush, in_valid, opcode, funct3, funct7, out_ready,
    input  in_ready, out_valid, alu_op, is_mdu, illegal, mdu_start, mdu_kill
  );

  modport slave (
    input  flush, in_valid, opcode, funct3, funct7, out_ready,
    output in_ready, out_valid, alu_op, is_mdu, illegal, mdu_start, mdu_kill
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// ID-stage ALU-op decoder: decodes RV32I (and optionally RV32M) into an ALUOp
// code, registered behind valid/ready, with M ops timed by a fixed-latency MDU slot.
module alu_op_sequencer #(
  parameter int ALUOP_W  = 5,
  parameter bit ENABLE_M = 1'b1,
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_op_sequencer_if.slave    bus,
  output logic [1:0]           state_dbg
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  // ALUOp codes shared with the EX stage.
  localparam logic [ALUOP_W-1:0] OP_IDLE = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] OP_ADD  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] OP_SUB  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] OP_SLL  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] OP_SLT  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] OP_SLTU = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] OP_XOR  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] OP_SRL  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] OP_SRA  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] OP_OR   = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] OP_AND  = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] OP_BEQ  = ALUOP_W'(11);
  localparam logic [ALUOP_W-1:0] OP_BNE  = ALUOP_W'(12);
  localparam logic [ALUOP_W-1:0] OP_BLT  = ALUOP_W'(13);
  localparam logic [ALUOP_W-1:0] OP_BGE  = ALUOP_W'(14);
  localparam logic [ALUOP_W-1:0] OP_BLTU = ALUOP_W'(15);
  localparam logic [ALUOP_W-1:0] OP_BGEU = ALUOP_W'(16);
  localparam logic [ALUOP_W-1:0] OP_MUL  = ALUOP_W'(17);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_MDU  = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   counter;
  logic               out_valid_q;
  logic [ALUOP_W-1:0] alu_op_q;
  logic               is_mdu_q;
  logic               illegal_q;
  logic               mdu_start_q;
  logic               mdu_kill_q;

  logic               in_ready;
  logic               accept;
  logic [ALUOP_W-1:0] dec_op;
  logic               dec_mdu;
  logic               dec_ill;
  logic [CNT_W-1:0]   dec_lat;

  function automatic logic [ALUOP_W-1:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  endfunction

  always_comb begin
    dec_op  = OP_IDLE;
    dec_mdu = 1'b0;
    dec_ill = 1'b0;
    dec_lat = CNT_W'(MUL_LAT);
    case (bus.opcode)
      OPC_LUI, OPC_JALR, OPC_LOAD, OPC_STORE: dec_op = OP_ADD;
      OPC_AUIPC, OPC_JAL:                     dec_op = OP_IDLE;
      OPC_BRANCH: begin
        case (bus.funct3)
          3'b000:  dec_op = OP_BEQ;
          3'b001:  dec_op = OP_BNE;
          3'b100:  dec_op = OP_BLT;
          3'b101:  dec_op = OP_BGE;
          3'b110:  dec_op = OP_BLTU;
          3'b111:  dec_op = OP_BGEU;
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        // funct7 is immediate data except for the shift-immediate forms.
        dec_op = base_op(bus.funct3);
        if (bus.funct3 == 3'b001 && bus.funct7 != F7_ZERO) dec_ill = 1'b1;
        if (bus.funct3 == 3'b101) begin
          if (bus.funct7 == F7_ALT)       dec_op  = OP_SRA;
          else if (bus.funct7 != F7_ZERO) dec_ill = 1'b1;
        end
      end
      OPC_OP: begin
        if (bus.funct7 == F7_ZERO) begin
          dec_op = base_op(bus.funct3);
        end else if (bus.funct7 == F7_ALT) begin
          case (bus.funct3)
            3'b000:  dec_op = OP_SUB;
            3'b101:  dec_op = OP_SRA;
            default: dec_ill = 1'b1;
          endcase
        end else if (ENABLE_M && bus.funct7 == F7_MULDIV) begin
          dec_mdu = 1'b1;
          dec_op  = OP_MUL + {{(ALUOP_W-3){1'b0}}, bus.funct3};
          dec_lat = bus.funct3[2] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        end else begin
          dec_ill = 1'b1;
        end
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_op  = OP_IDLE;
      dec_mdu = 1'b0;
    end
  end

  assign in_ready = (state == ST_IDLE) || (state == ST_HOLD && bus.out_ready);
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      counter     <= '0;
      out_valid_q <= 1'b0;
      alu_op_q    <= OP_IDLE;
      is_mdu_q    <= 1'b0;
      illegal_q   <= 1'b0;
      mdu_start_q <= 1'b0;
      mdu_kill_q  <= 1'b0;
    end else begin
      mdu_start_q <= 1'b0;
      mdu_kill_q  <= 1'b0;
      if (bus.flush) begin
        // Registered fields are left as-is; out_valid=0 marks them stale.
        state       <= ST_IDLE;
        out_valid_q <= 1'b0;
        counter     <= '0;
        mdu_kill_q  <= (state == ST_MDU);
      end else begin
        case (state)
          ST_IDLE, ST_HOLD: begin
            if (accept) begin
              alu_op_q  <= dec_op;
              is_mdu_q  <= dec_mdu;
              illegal_q <= dec_ill;
              if (dec_mdu) begin
                state       <= ST_MDU;
                out_valid_q <= 1'b0;
                mdu_start_q <= 1'b1;
                counter     <= dec_lat;
              end else begin
                state       <= ST_HOLD;
                out_valid_q <= 1'b1;
              end
            end else if (state == ST_HOLD && bus.out_ready) begin
              state       <= ST_IDLE;
              out_valid_q <= 1'b0;
            end
          end
          ST_MDU: begin
            if (counter <= CNT_W'(1)) begin
              state       <= ST_HOLD;
              out_valid_q <= 1'b1;
              counter     <= '0;
            end else begin
              counter <= counter - CNT_W'(1);
            end
          end
          default: begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.is_mdu    = is_mdu_q;
  assign bus.illegal   = illegal_q;
  assign bus.mdu_start = mdu_start_q;
  assign bus.mdu_kill  = mdu_kill_q;
  assign state_dbg     = state;
endmodule
